kv_xfer_engine: RTL and testbench
=================================

Name: kv_xfer_engine

Overview:
Executes the KV cache microcode ops: OP_KV_APPEND (opcode 8) and OP_KV_READ (opcode 9). It takes one 128-bit instruction word from the sequencer and decodes the KV field mapping. It then streams elements, one per cycle, between SRAM0 and the KV cache bank. OP_KV_APPEND moves SRAM0 → KV; OP_KV_READ moves KV → SRAM0. It sits between the instruction dispatcher and kv_cache_bank, and pulses done/err back to the dispatcher when the transfer completes.

Parameters:
DATA_W, 8, element width (int8).
LAYER_W, 2, layer_id bits used.
HEAD_W, 2, head_id bits used.
TIME_W, 6, time index bits (MAX_T = 2^TIME_W).
DIM_W, 6, element index bits (MAX_DIM = 2^DIM_W).

Ports:
clk  in  1  clock.
rst  in  1  asynchronous, active-high reset.
instr_valid  in  1  dispatcher offers instruction.
instr_ready  out  1  engine idle, can accept.
instr  in  128  microcode word.
done  out  1  one-cycle completion pulse.
err  out  1  valid with done; 1 = instruction rejected.
busy  out  1  high from accept until done inclusive.
sram_rd_en  out  1  SRAM0 read strobe.
sram_rd_addr  out  16  SRAM0 read address.
sram_rd_data  in  DATA_W  SRAM0 data; 1-cycle latency.
sram_wr_en  out  1  SRAM0 write strobe.
sram_wr_addr  out  16  SRAM0 write address.
sram_wr_data  out  DATA_W  SRAM0 write data.
kv_rd_en  out  1  KV read strobe.
kv_wr_en  out  1  KV write strobe.
kv_addr  out  1+LAYER_W+HEAD_W+TIME_W+DIM_W  {is_v, layer, head, time, elem}; shared by read and write.
kv_wr_data  out  DATA_W  KV write data.
kv_rd_data  in  DATA_W  KV data; 1-cycle latency.

Behaviour:
- Reset (asynchronous, active-high): state IDLE. All strobes, done, err and busy are 0. Addresses and data are 0. instr_ready is 1 once rst deasserts.
- Decode uses these fields:
  - opcode [7:0]; flags [15:8], bit0 = is_v.
  - dst_base [31:16]; src0_base [47:32].
  - M [79:64] = layer; N [95:80] = vector length.
  - K [111:96] = time index for APPEND, time_len for READ.
  - imm [127:112] = head.
- Accept condition: instr_valid & instr_ready. instr_ready = (state == IDLE). All fields are latched at accept; instr is don't-care afterwards.
- Error checks at accept (err = 1, no memory access, done in cycle 1):
  - opcode not 8 or 9;
  - layer ≥ 2^LAYER_W;
  - head ≥ 2^HEAD_W;
  - N > MAX_DIM;
  - APPEND with time ≥ MAX_T;
  - READ with time_len > MAX_T.
- Transfer count C = N for APPEND and K·N for READ. If C = 0 and there is no error, done is raised in cycle 1 with err = 0 and no strobes.
- States: IDLE → RUN (C > 0, legal) → DRAIN → DONE → IDLE. IDLE → DONE directly on error or C = 0.
- Timing, with cycle numbering relative to the accept edge:
  - RUN: reads issued in cycles 1..C.
  - Writes issued in cycles 2..C+1; each write lands one cycle after its read (DRAIN covers cycle C+1).
  - done = 1 in cycle C+2; instr_ready returns in cycle C+3.
- APPEND, element e (0..N-1):
  - read sram_rd_addr = src0 + e;
  - write kv_addr = {is_v, layer, head, time, e}, kv_wr_data = returned sram_rd_data.
- READ, time t (0..K-1) outer loop, element e inner loop:
  - kv_rd_en with kv_addr = {is_v, layer, head, t, e};
  - one cycle later, sram_wr_addr = dst + t·N + e, sram_wr_data = kv_rd_data.
  - Because kv_addr is shared, kv_rd_en and kv_wr_en are never both high (READ uses only kv_rd_en).
- Address arithmetic: SRAM addresses are 16-bit and wrap modulo 2^16 (0xFFFF + 1 = 0x0000). The element counter is DIM_W+1 bits so N = MAX_DIM is legal.
- done and err are asserted together for exactly 1 cycle. err is 0 whenever done is 0. busy = !instr_ready.
- Reset mid-transfer: all strobes deassert immediately (asynchronously). The transfer is abandoned, no done is emitted, and the KV and SRAM contents already written are left as-is.
- instr_valid while busy is ignored, with no side effects.

Test Plan:
1. APPEND, is_v = 0, layer 1, head 2, time 5, N = 4, src0 = 0x0010, SRAM[0x10..0x13] = 0x11..0x14 → kv_wr_en in cycles 2..5 at {0,1,2,5,0..3} with data 0x11..0x14; done = 1, err = 0 in cycle 6.
2. READ, is_v = 1, layer 1, head 2, K = 3, N = 4, dst = 0x0100, KV preloaded with t·16 + e → 12 SRAM writes at 0x0100..0x010B in t-major order, data 0x00..0x03, 0x10..0x13, 0x20..0x23; done in cycle 14.
3. APPEND with N = 0, and READ with K = 0 → done = 1, err = 0 in cycle 1; zero strobes; instr_ready back in cycle 2.
4. Rejected instructions → done = 1, err = 1 in cycle 1 and no strobes, for each of:
   - opcode 0x05;
   - APPEND with time = 64;
   - head = 4;
   - N = 65.
5. dst = 0xFFFE, READ K = 1, N = 4 → SRAM writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
6. rst pulsed in cycle 3 of test 2 → all strobes 0 immediately, no done, instr_ready = 1 after release. A following APPEND with instr_valid held high through two back-to-back instructions → the second is accepted in the cycle after the first's done.

Source files
------------

// File: rtl/kv_xfer_engine_if.sv
// Dispatcher handshake plus SRAM0 / KV-bank ports of the KV transfer engine.
// The engine connects through the slave modport; the master modport is the surrounding fabric.
interface kv_xfer_engine_if #(
  parameter int DATA_W  = 8,
  parameter int LAYER_W = 2,
  parameter int HEAD_W  = 2,
  parameter int TIME_W  = 6,
  parameter int DIM_W   = 6
);
  localparam int KV_AW = 1 + LAYER_W + HEAD_W + TIME_W + DIM_W;

  logic              instr_valid;
  logic              instr_ready;
  logic [127:0]      instr;
  logic              done;
  logic              err;
  logic              busy;
  logic              sram_rd_en;
  logic [15:0]       sram_rd_addr;
  logic [DATA_W-1:0] sram_rd_data;
  logic              sram_wr_en;
  logic [15:0]       sram_wr_addr;
  logic [DATA_W-1:0] sram_wr_data;
  logic              kv_rd_en;
  logic              kv_wr_en;
  logic [KV_AW-1:0]  kv_addr;
  logic [DATA_W-1:0] kv_wr_data;
  logic [DATA_W-1:0] kv_rd_data;

  modport slave (
    input  instr_valid, instr, sram_rd_data, kv_rd_data,
    output instr_ready, done, err, busy,
           sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
           kv_rd_en, kv_wr_en, kv_addr, kv_wr_data
  );

  modport master (
    output instr_valid, instr, sram_rd_data, kv_rd_data,
    input  instr_ready, done, err, busy,
           sram_rd_en, sram_rd_addr, sram_wr_en, sram_wr_addr, sram_wr_data,
           kv_rd_en, kv_wr_en, kv_addr, kv_wr_data
  );
endinterface

// File: rtl/kv_xfer_engine.sv
// KV cache microcode engine: APPEND streams SRAM0 -> KV, READ streams KV -> SRAM0,
// one element per cycle, with a one-cycle read-to-write pipeline.
module kv_xfer_engine #(
  parameter int DATA_W  = 8,
  parameter int LAYER_W = 2,
  parameter int HEAD_W  = 2,
  parameter int TIME_W  = 6,
  parameter int DIM_W   = 6
) (
  input  logic              clk,
  input  logic              rst,
  kv_xfer_engine_if.slave   bus
);
  localparam int unsigned MAX_T     = 1 << TIME_W;
  localparam int unsigned MAX_DIM   = 1 << DIM_W;
  localparam int unsigned LAYER_LIM = 1 << LAYER_W;
  localparam int unsigned HEAD_LIM  = 1 << HEAD_W;
  localparam int          CW        = TIME_W + DIM_W + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_nx;

  logic [7:0]  d_op;
  logic [15:0] d_layer, d_n, d_k, d_head;
  logic        d_is_read, d_err;
  logic [CW-1:0] d_count;
  logic        accept;
  logic        unused_bits;

  assign d_op        = bus.instr[7:0];
  assign d_layer     = bus.instr[79:64];
  assign d_n         = bus.instr[95:80];
  assign d_k         = bus.instr[111:96];
  assign d_head      = bus.instr[127:112];
  assign accept      = bus.instr_valid && (state == IDLE);
  assign unused_bits = ^{bus.instr[63:48], bus.instr[15:9]};

  always_comb begin
    d_is_read = (d_op == 8'd9);
    d_err = ((d_op != 8'd8) && (d_op != 8'd9))
         || ({16'd0, d_layer} >= LAYER_LIM)
         || ({16'd0, d_head}  >= HEAD_LIM)
         || ({16'd0, d_n}     >  MAX_DIM)
         || (!d_is_read && ({16'd0, d_k} >= MAX_T))
         || ( d_is_read && ({16'd0, d_k} >  MAX_T));
    // Field slices are only meaningful once d_err is clear.
    if (d_is_read)
      d_count = CW'(d_k[TIME_W:0]) * CW'(d_n[DIM_W:0]);
    else
      d_count = CW'(d_n[DIM_W:0]);
  end

  logic                is_read, is_v, err_q;
  logic [LAYER_W-1:0]  layer;
  logic [HEAD_W-1:0]   head;
  logic [TIME_W-1:0]   time_idx, t_rd;
  logic [DIM_W:0]      n_len, e_rd, e_nx;
  logic [15:0]         src0, dst, rd_lin, wr_lin;
  logic [CW-1:0]       rd_left;
  logic                wr_pend;
  logic [DIM_W-1:0]    wr_e;

  assign e_nx = e_rd + (DIM_W+1)'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (d_err || d_count == '0) ? DONE : RUN;
      RUN:     if (rd_left == CW'(1)) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_read  <= 1'b0;
      is_v     <= 1'b0;
      err_q    <= 1'b0;
      layer    <= '0;
      head     <= '0;
      time_idx <= '0;
      n_len    <= '0;
      src0     <= '0;
      dst      <= '0;
      rd_left  <= '0;
      e_rd     <= '0;
      t_rd     <= '0;
      rd_lin   <= '0;
      wr_pend  <= 1'b0;
      wr_lin   <= '0;
      wr_e     <= '0;
    end else begin
      wr_pend <= (state == RUN);
      wr_lin  <= rd_lin;
      wr_e    <= e_rd[DIM_W-1:0];
      if (accept) begin
        is_read  <= d_is_read;
        is_v     <= bus.instr[8];
        err_q    <= d_err;
        layer    <= d_layer[LAYER_W-1:0];
        head     <= d_head[HEAD_W-1:0];
        time_idx <= d_k[TIME_W-1:0];
        n_len    <= d_n[DIM_W:0];
        dst      <= bus.instr[31:16];
        src0     <= bus.instr[47:32];
        rd_left  <= d_count;
        e_rd     <= '0;
        t_rd     <= '0;
        rd_lin   <= '0;
      end else if (state == RUN) begin
        rd_left <= rd_left - CW'(1);
        rd_lin  <= rd_lin + 16'd1;
        // Element index wraps at N and carries into the time index (READ walks t-major).
        if (e_nx == n_len) begin
          e_rd <= '0;
          t_rd <= t_rd + TIME_W'(1);
        end else begin
          e_rd <= e_nx;
        end
      end
    end
  end

  always_comb begin
    bus.instr_ready  = (state == IDLE);
    bus.busy         = (state != IDLE);
    bus.done         = (state == DONE);
    bus.err          = (state == DONE) && err_q;
    bus.sram_rd_en   = 1'b0;
    bus.sram_rd_addr = '0;
    bus.sram_wr_en   = 1'b0;
    bus.sram_wr_addr = '0;
    bus.sram_wr_data = '0;
    bus.kv_rd_en     = 1'b0;
    bus.kv_wr_en     = 1'b0;
    bus.kv_addr      = '0;
    bus.kv_wr_data   = '0;
    if (state == RUN) begin
      if (is_read) begin
        bus.kv_rd_en = 1'b1;
        bus.kv_addr  = {is_v, layer, head, t_rd, e_rd[DIM_W-1:0]};
      end else begin
        bus.sram_rd_en   = 1'b1;
        bus.sram_rd_addr = src0 + rd_lin;
      end
    end
    if (wr_pend) begin
      if (is_read) begin
        bus.sram_wr_en   = 1'b1;
        bus.sram_wr_addr = dst + wr_lin;
        bus.sram_wr_data = bus.kv_rd_data;
      end else begin
        bus.kv_wr_en   = 1'b1;
        bus.kv_addr    = {is_v, layer, head, time_idx, wr_e};
        bus.kv_wr_data = bus.sram_rd_data;
      end
    end
  end
endmodule

// File: tb/tb_kv_xfer_engine.sv
// Directed bench for kv_xfer_engine with behavioural SRAM0 and KV-bank models.
module tb_kv_xfer_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kv_xfer_engine_if bus ();
  kv_xfer_engine dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] sram_mem [0:65535];
  logic [7:0] kv_mem   [0:131071];

  // 1-cycle-latency memories; data registered, array updated after the read.
  always @(posedge clk) begin
    if (bus.sram_rd_en) bus.sram_rd_data <= sram_mem[bus.sram_rd_addr];
    if (bus.kv_rd_en)   bus.kv_rd_data   <= kv_mem[bus.kv_addr];
    if (bus.sram_wr_en) sram_mem[bus.sram_wr_addr] = bus.sram_wr_data;
    if (bus.kv_wr_en)   kv_mem[bus.kv_addr]        = bus.kv_wr_data;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mk(input logic [7:0] op, input logic [7:0] fl,
                                      input logic [15:0] dst, input logic [15:0] src,
                                      input logic [15:0] m, input logic [15:0] n,
                                      input logic [15:0] k, input logic [15:0] imm);
    return {imm, k, n, m, 16'h0000, src, dst, fl, op};
  endfunction

  function automatic logic [16:0] kva(input logic v, input logic [1:0] l, input logic [1:0] h,
                                      input logic [5:0] t, input logic [5:0] e);
    return {v, l, h, t, e};
  endfunction

  task automatic send(input logic [127:0] w);
    @(negedge clk);
    chk("ready_before_accept", bus.instr_ready, 1);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    bus.instr       = {$urandom(), $urandom(), $urandom(), $urandom()};
  endtask

  task automatic check_append(input logic [15:0] src, input logic v, input logic [1:0] l,
                              input logic [1:0] h, input logic [5:0] t, input int n,
                              input logic [7:0] d0);
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      chk("ap_sram_rd_en", bus.sram_rd_en, c <= n);
      if (c <= n) chk("ap_sram_rd_addr", bus.sram_rd_addr, 16'(src + c - 1));
      chk("ap_kv_wr_en", bus.kv_wr_en, (c >= 2) && (c <= n + 1));
      if ((c >= 2) && (c <= n + 1)) begin
        chk("ap_kv_addr", bus.kv_addr, kva(v, l, h, t, 6'(c - 2)));
        chk("ap_kv_wr_data", bus.kv_wr_data, d0 + 8'(c - 2));
      end
      chk("ap_kv_rd_en", bus.kv_rd_en, 0);
      chk("ap_sram_wr_en", bus.sram_wr_en, 0);
      chk("ap_done", bus.done, c == n + 2);
      chk("ap_err", bus.err, 0);
      chk("ap_busy", bus.busy, 1);
    end
    @(negedge clk);
    chk("ap_ready_after", bus.instr_ready, 1);
    chk("ap_done_after", bus.done, 0);
  endtask

  task automatic check_read(input logic [15:0] dst, input logic v, input logic [1:0] l,
                            input logic [1:0] h, input int k, input int n);
    int cnt;
    int i;
    cnt = k * n;
    for (int c = 1; c <= cnt + 2; c++) begin
      @(negedge clk);
      chk("rd_kv_rd_en", bus.kv_rd_en, c <= cnt);
      if (c <= cnt) chk("rd_kv_addr", bus.kv_addr, kva(v, l, h, 6'((c - 1) / n), 6'((c - 1) % n)));
      chk("rd_sram_wr_en", bus.sram_wr_en, (c >= 2) && (c <= cnt + 1));
      if ((c >= 2) && (c <= cnt + 1)) begin
        i = c - 2;
        chk("rd_sram_wr_addr", bus.sram_wr_addr, 16'(dst + i));
        chk("rd_sram_wr_data", bus.sram_wr_data, 8'((i / n) * 16 + (i % n)));
      end
      chk("rd_kv_wr_en", bus.kv_wr_en, 0);
      chk("rd_sram_rd_en", bus.sram_rd_en, 0);
      chk("rd_done", bus.done, c == cnt + 2);
      chk("rd_err", bus.err, 0);
    end
    @(negedge clk);
    chk("rd_ready_after", bus.instr_ready, 1);
  endtask

  task automatic check_imm(input string tag, input logic err_exp);
    @(negedge clk);
    chk({tag, "_done"}, bus.done, 1);
    chk({tag, "_err"}, bus.err, err_exp);
    chk({tag, "_strobes"}, {bus.sram_rd_en, bus.sram_wr_en, bus.kv_rd_en, bus.kv_wr_en}, 0);
    @(negedge clk);
    chk({tag, "_ready"}, bus.instr_ready, 1);
    chk({tag, "_done_low"}, bus.done, 0);
    chk({tag, "_err_low"}, bus.err, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    sram_mem[16'h0010] = 8'h11; sram_mem[16'h0011] = 8'h12;
    sram_mem[16'h0012] = 8'h13; sram_mem[16'h0013] = 8'h14;
    sram_mem[16'h0020] = 8'hA0; sram_mem[16'h0021] = 8'hA1;
    sram_mem[16'h0030] = 8'hB0; sram_mem[16'h0031] = 8'hB1;
    sram_mem[16'hFFFE] = 8'h55; sram_mem[16'h0001] = 8'h55;
    for (int t = 0; t < 3; t++)
      for (int e = 0; e < 4; e++)
        kv_mem[kva(1'b1, 2'd1, 2'd2, 6'(t), 6'(e))] = 8'(t * 16 + e);

    // Reset state
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_strobes", {bus.sram_rd_en, bus.sram_wr_en, bus.kv_rd_en, bus.kv_wr_en}, 0);
    chk("rst_kv_addr", bus.kv_addr, 0);
    chk("rst_sram_rd_addr", bus.sram_rd_addr, 0);
    chk("rst_sram_wr_addr", bus.sram_wr_addr, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", bus.instr_ready, 1);

    // 1: APPEND is_v=0 layer1 head2 time5 N=4 src0=0x10
    send(mk(8'd8, 8'h00, 16'h0000, 16'h0010, 16'd1, 16'd4, 16'd5, 16'd2));
    check_append(16'h0010, 1'b0, 2'd1, 2'd2, 6'd5, 4, 8'h11);
    chk("t1_kv_mem0", kv_mem[kva(1'b0, 2'd1, 2'd2, 6'd5, 6'd0)], 8'h11);
    chk("t1_kv_mem3", kv_mem[kva(1'b0, 2'd1, 2'd2, 6'd5, 6'd3)], 8'h14);

    // 2: READ is_v=1 layer1 head2 K=3 N=4 dst=0x100
    send(mk(8'd9, 8'h01, 16'h0100, 16'h0000, 16'd1, 16'd4, 16'd3, 16'd2));
    check_read(16'h0100, 1'b1, 2'd1, 2'd2, 3, 4);
    chk("t2_sram_mem_10b", sram_mem[16'h010B], 8'h23);
    chk("t2_sram_mem_104", sram_mem[16'h0104], 8'h10);

    // 3: zero-length transfers
    send(mk(8'd8, 8'h00, 16'h0000, 16'h0010, 16'd1, 16'd0, 16'd5, 16'd2));
    check_imm("t3_append_n0", 1'b0);
    send(mk(8'd9, 8'h01, 16'h0100, 16'h0000, 16'd1, 16'd4, 16'd0, 16'd2));
    check_imm("t3_read_k0", 1'b0);

    // 4: rejected instructions
    send(mk(8'd5, 8'h00, 16'h0000, 16'h0010, 16'd1, 16'd4, 16'd5, 16'd2));
    check_imm("t4_bad_op", 1'b1);
    send(mk(8'd8, 8'h00, 16'h0000, 16'h0010, 16'd1, 16'd4, 16'd64, 16'd2));
    check_imm("t4_time64", 1'b1);
    send(mk(8'd8, 8'h00, 16'h0000, 16'h0010, 16'd1, 16'd4, 16'd5, 16'd4));
    check_imm("t4_head4", 1'b1);
    send(mk(8'd9, 8'h01, 16'h0100, 16'h0000, 16'd1, 16'd65, 16'd1, 16'd2));
    check_imm("t4_n65", 1'b1);

    // 5: SRAM address wrap
    send(mk(8'd9, 8'h01, 16'hFFFE, 16'h0000, 16'd1, 16'd4, 16'd1, 16'd2));
    check_read(16'hFFFE, 1'b1, 2'd1, 2'd2, 1, 4);
    chk("t5_sram_fffe", sram_mem[16'hFFFE], 8'h00);
    chk("t5_sram_0001", sram_mem[16'h0001], 8'h03);

    // 6: reset in cycle 3 of a READ
    send(mk(8'd9, 8'h01, 16'h0100, 16'h0000, 16'd1, 16'd4, 16'd3, 16'd2));
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_strobes_async", {bus.sram_rd_en, bus.sram_wr_en, bus.kv_rd_en, bus.kv_wr_en}, 0);
    chk("t6_busy_async", bus.busy, 0);
    chk("t6_done_async", bus.done, 0);
    @(posedge clk);
    @(negedge clk);
    chk("t6_done_in_rst", bus.done, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_ready_after", bus.instr_ready, 1);
    chk("t6_no_done", bus.done, 0);

    // 6b: back-to-back APPENDs with instr_valid held high
    @(negedge clk);
    bus.instr_valid = 1'b1;
    bus.instr = mk(8'd8, 8'h00, 16'h0000, 16'h0020, 16'd2, 16'd2, 16'd7, 16'd1);
    @(posedge clk);
    #1;
    bus.instr = mk(8'd8, 8'h00, 16'h0000, 16'h0030, 16'd3, 16'd2, 16'd8, 16'd3);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk("b2b_busy", bus.busy, 1);
      chk("b2b_rd_en", bus.sram_rd_en, c <= 2);
      if (c <= 2) chk("b2b_rd_addr", bus.sram_rd_addr, 16'(16'h0020 + c - 1));
      chk("b2b_kv_wr_en", bus.kv_wr_en, (c >= 2) && (c <= 3));
      if ((c >= 2) && (c <= 3)) chk("b2b_kv_addr", bus.kv_addr, kva(1'b0, 2'd2, 2'd1, 6'd7, 6'(c - 2)));
      chk("b2b_done", bus.done, c == 4);
    end
    @(negedge clk);
    chk("b2b_ready_gap", bus.instr_ready, 1);
    chk("b2b_done_gap", bus.done, 0);
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(negedge clk);
    chk("b2b2_busy", bus.busy, 1);
    chk("b2b2_rd_en", bus.sram_rd_en, 1);
    chk("b2b2_rd_addr", bus.sram_rd_addr, 16'h0030);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("b2b2_done", bus.done, 1);
    chk("b2b2_err", bus.err, 0);
    @(negedge clk);
    chk("b2b2_ready", bus.instr_ready, 1);
    chk("b2b_kv_first", kv_mem[kva(1'b0, 2'd2, 2'd1, 6'd7, 6'd1)], 8'hA1);
    chk("b2b_kv_second", kv_mem[kva(1'b0, 2'd3, 2'd3, 6'd8, 6'd1)], 8'hB1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
